// File: rtl/mips16_pkg.sv
// Shared constants for the 16-bit single-cycle MIPS core:
// opcodes, function codes, PC select codes, field positions, fetch states.
package mips16_pkg;

    localparam logic [2:0] OPC_RTYPE = 3'b000;
    localparam logic [2:0] OPC_ADDI  = 3'b001;
    localparam logic [2:0] OPC_SW    = 3'b010;
    localparam logic [2:0] OPC_BEQ   = 3'b011;
    localparam logic [2:0] OPC_LW    = 3'b100;
    localparam logic [2:0] OPC_J     = 3'b101;
    localparam logic [2:0] OPC_SLTI  = 3'b110;
    localparam logic [2:0] OPC_JAL   = 3'b111;

    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_AND = 4'h2;
    localparam logic [3:0] FN_OR  = 4'h3;
    localparam logic [3:0] FN_SLT = 4'h4;
    localparam logic [3:0] FN_JR  = 4'h8;

    localparam logic [1:0] PC_SEL_INC = 2'b00;
    localparam logic [1:0] PC_SEL_JR  = 2'b01;
    localparam logic [1:0] PC_SEL_BR  = 2'b10;
    localparam logic [1:0] PC_SEL_J   = 2'b11;

    localparam int OPC_LSB = 13;
    localparam int RS_LSB  = 10;
    localparam int RT_LSB  = 7;
    localparam int RD_LSB  = 4;
    localparam int FN_LSB  = 0;
    localparam int JT_W    = 13;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus.
// master = fetch sequencer, slave = instruction memory.
interface fetch_sequencer_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection: increment, jr, branch, jump.
// All arithmetic wraps at PC_W bits.
module next_pc_calc
    import mips16_pkg::*;
#(
    parameter int PC_W  = 16,
    parameter int IMM_W = 7
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [IMM_W-1:0] imm,
    input  logic [JT_W-1:0]  jtarget,
    input  logic [PC_W-1:0]  rs_data,
    input  logic [1:0]       pc_sel,
    output logic [PC_W-1:0]  next_pc,
    output logic [PC_W-1:0]  link_pc
);
    logic [PC_W-1:0] inc;
    logic [PC_W-1:0] simm;

    assign inc     = pc + PC_W'(1);
    assign simm    = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign link_pc = inc;

    always_comb begin
        next_pc = inc;
        unique case (pc_sel)
            PC_SEL_INC: next_pc = inc;
            PC_SEL_JR:  next_pc = rs_data;
            PC_SEL_BR:  next_pc = inc + simm;
            PC_SEL_J:   next_pc = {pc[PC_W-1:JT_W], jtarget};
        endcase
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/PC sequencer: fetches over imem req/ack, holds IR,
// exposes decoded fields and advances PC from the control unit's select.
module fetch_sequencer
    import mips16_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              IMM_W    = 7
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  imem,
    input  logic               stall,
    input  logic [1:0]         PC_sel,
    input  logic               HLT_RST,
    input  logic [PC_W-1:0]    rs_data,
    output logic [2:0]         opcode,
    output logic [3:0]         function_extend,
    output logic [2:0]         rs,
    output logic [2:0]         rt,
    output logic [2:0]         rd,
    output logic [IMM_W-1:0]   imm,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    link_pc,
    output logic               instr_valid,
    output logic               halted
);
    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     ir_q;
    logic [PC_W-1:0] next_pc;
    logic            ld_pc;
    logic            ld_ir;

    // S_IDLE keeps imem_req low for one cycle after reset so a late ack is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ld_pc) pc_q <= next_pc;
            if (ld_ir) ir_q <= imem.imem_rdata;
        end
    end

    always_comb begin
        state_d       = state_q;
        ld_pc         = 1'b0;
        ld_ir         = 1'b0;
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        halted        = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    ld_ir   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    if (!HLT_RST) begin
                        state_d = S_HALT;
                    end else begin
                        ld_pc   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign imem.imem_addr  = pc_q;
    assign pc              = pc_q;
    assign opcode          = ir_q[OPC_LSB +: 3];
    assign rs              = ir_q[RS_LSB +: 3];
    assign rt              = ir_q[RT_LSB +: 3];
    assign rd              = ir_q[RD_LSB +: 3];
    assign function_extend = ir_q[FN_LSB +: 4];
    assign imm             = ir_q[IMM_W-1:0];

    next_pc_calc #(
        .PC_W  (PC_W),
        .IMM_W (IMM_W)
    ) u_next_pc (
        .pc      (pc_q),
        .imm     (ir_q[IMM_W-1:0]),
        .jtarget (ir_q[JT_W-1:0]),
        .rs_data (rs_data),
        .pc_sel  (PC_sel),
        .next_pc (next_pc),
        .link_pc (link_pc)
    );
endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer with a transaction-level
// reference model and directed literal checks.
module tb_fetch_sequencer;
    import mips16_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic [1:0]  PC_sel;
    logic        HLT_RST;
    logic [15:0] rs_data;
    logic [2:0]  opcode, rs, rt, rd;
    logic [3:0]  function_extend;
    logic [6:0]  imm;
    logic [15:0] pc, link_pc;
    logic        instr_valid, halted;

    fetch_sequencer_if #(.PC_W(16)) bus ();

    fetch_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (bus),
        .stall           (stall),
        .PC_sel          (PC_sel),
        .HLT_RST         (HLT_RST),
        .rs_data         (rs_data),
        .opcode          (opcode),
        .function_extend (function_extend),
        .rs              (rs),
        .rt              (rt),
        .rd              (rd),
        .imm             (imm),
        .pc              (pc),
        .link_pc         (link_pc),
        .instr_valid     (instr_valid),
        .halted          (halted)
    );

    typedef enum int {MD_IDLE, MD_FETCH, MD_EXEC, MD_HALT} mode_t;

    mode_t       m_mode = MD_IDLE;
    int unsigned m_pc   = 0;
    logic [15:0] m_ir   = '0;
    bit          chk_en = 1'b0;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          req_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int unsigned target(int unsigned p, logic [15:0] ir,
                                           logic [1:0] sel, int unsigned rsv);
        int s;
        s = ir[6] ? int'(ir[6:0]) - 128 : int'(ir[6:0]);
        case (sel)
            2'd0:    return (p + 1) % 65536;
            2'd1:    return rsv % 65536;
            2'd2:    return int'((int'(p) + 1 + s) & 'hFFFF);
            default: return (p & 32'hE000) | (int'(ir) & 32'h1FFF);
        endcase
    endfunction

    // one clock of stimulus; model advances from the inputs just applied
    task automatic step(bit r, bit a, logic [15:0] w, bit st, bit h,
                        logic [1:0] sel, logic [15:0] rsv);
        rst            = r;
        bus.imem_ack   = a;
        bus.imem_rdata = w;
        stall          = st;
        HLT_RST        = h;
        PC_sel         = sel;
        rs_data        = rsv;
        @(posedge clk);
        #1;
        if (r) begin
            m_mode = MD_IDLE;
            m_pc   = 0;
            m_ir   = '0;
            chk_en = 1'b1;
        end else begin
            case (m_mode)
                MD_IDLE:  m_mode = MD_FETCH;
                MD_FETCH: if (a) begin
                    m_ir   = w;
                    m_mode = MD_EXEC;
                end
                MD_EXEC: if (!st) begin
                    if (!h) m_mode = MD_HALT;
                    else begin
                        m_pc   = target(m_pc, m_ir, sel, rsv);
                        m_mode = MD_FETCH;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic rstep(bit r);
        step(r, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             2'($urandom), 16'($urandom));
    endtask

    task automatic fetch_instr(logic [15:0] w, int delay);
        if (m_mode == MD_IDLE) rstep(1'b0);
        for (int k = 1; k <= delay; k++)
            step(1'b0, k == delay, w, 1'($urandom), 1'($urandom),
                 2'($urandom), 16'($urandom));
    endtask

    task automatic exec_instr(logic [1:0] sel, logic [15:0] rsv, bit h,
                              int nstall);
        for (int i = 0; i < nstall; i++)
            step(1'b0, 1'($urandom), 16'($urandom), 1'b1,
                 h & 1'($urandom), 2'($urandom), 16'($urandom));
        step(1'b0, 1'($urandom), 16'($urandom), 1'b0, h, sel, rsv);
    endtask

    task automatic jump_to(logic [15:0] a);
        fetch_instr(16'h0008, 1);
        exec_instr(2'b01, a, 1'b1, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req", bus.imem_req, m_mode == MD_FETCH);
            chk("instr_valid", instr_valid, m_mode == MD_EXEC);
            chk("halted", halted, m_mode == MD_HALT);
            chk("pc", pc, m_pc);
            chk("link_pc", link_pc, (m_pc + 1) % 65536);
            if (m_mode == MD_FETCH) chk("imem_addr", bus.imem_addr, m_pc);
            if (m_mode == MD_EXEC) begin
                chk("opcode", opcode, m_ir[15:13]);
                chk("rs", rs, m_ir[12:10]);
                chk("rt", rt, m_ir[9:7]);
                chk("rd", rd, m_ir[6:4]);
                chk("funct", function_extend, m_ir[3:0]);
                chk("imm", imm, m_ir[6:0]);
            end
            if (bus.imem_req === 1'b1) req_cnt++;
        end
    end

    initial begin
        rstep(1'b1);
        rstep(1'b1);
        chk("rst_req", bus.imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 16'h0000);

        req_cnt = 0;
        fetch_instr(16'h0000, 3);
        chk("t1_req_cycles", req_cnt, 3);
        exec_instr(2'b00, 16'($urandom), 1'b1, 0);
        chk("t1_pc", pc, 16'h0001);

        jump_to(16'h0010);
        fetch_instr(16'h6C7E, 2);
        exec_instr(2'b10, 16'($urandom), 1'b1, 0);
        chk("t2_beq_taken", pc, 16'h000F);
        jump_to(16'h0010);
        fetch_instr(16'h6C7E, 1);
        exec_instr(2'b00, 16'($urandom), 1'b1, 0);
        chk("t2_beq_not", pc, 16'h0011);

        jump_to(16'h2005);
        fetch_instr(16'hA123, 1);
        exec_instr(2'b11, 16'($urandom), 1'b1, 1);
        chk("t3_j", pc, 16'h2123);
        jump_to(16'h0040);
        fetch_instr(16'hE055, 2);
        chk("t3_link", link_pc, 16'h0041);
        exec_instr(2'b11, 16'($urandom), 1'b1, 0);
        chk("t3_jal", pc, 16'h0055);

        fetch_instr(16'h0008, 1);
        exec_instr(2'b01, 16'hBEEF, 1'b1, 0);
        chk("t4_jr", pc, 16'hBEEF);
        jump_to(16'hFFFF);
        fetch_instr(16'h1234, 1);
        exec_instr(2'b00, 16'($urandom), 1'b1, 0);
        chk("t4_wrap", pc, 16'h0000);

        jump_to(16'h1234);
        fetch_instr(16'h0000, 1);
        exec_instr(2'b00, 16'($urandom), 1'b0, 0);
        chk("t5_halted", halted, 1);
        chk("t5_req", bus.imem_req, 0);
        repeat (20) rstep(1'b0);
        chk("t5_frozen", pc, 16'h1234);
        rstep(1'b1);
        chk("t5_rst_pc", pc, 16'h0000);
        rstep(1'b0);
        chk("t5_resume", bus.imem_req, 1);

        jump_to(16'h0300);
        fetch_instr(16'h1111, 1);
        exec_instr(2'b11, 16'($urandom), 1'b0, 4);
        chk("t6_stall_pc", pc, 16'h0300);
        chk("t6_halted", halted, 1);
        rstep(1'b1);
        rstep(1'b0);
        step(1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 2'b00, 16'h0);
        step(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 2'b00, 16'h0);
        step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 2'b00, 16'h0);
        chk("t6_late_ack_ir", {opcode, rs, rt, rd, function_extend}, 0);
        chk("t6_late_ack_valid", instr_valid, 0);
        chk("t6_refetch", bus.imem_req, 1);

        repeat (300) begin
            if (m_mode == MD_HALT) begin
                repeat ($urandom_range(1, 3)) rstep(1'b0);
                rstep(1'b1);
            end
            fetch_instr(16'($urandom), $urandom_range(1, 4));
            exec_instr(2'($urandom), 16'($urandom),
                       ($urandom % 25) != 0, $urandom % 3);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
